uart_rx_engine: RTL and testbench
=================================

Name: uart_rx_engine

Overview:
- Receive engine fed directly by the buffered serial-in pin (`O_RX` of the pad-buffer stage).
- Synchronizes the asynchronous line and detects start bits.
- Samples each bit at mid-bit-time and assembles 7- or 8-bit characters, with optional parity.
- Presents each character with ready, parity, framing and overrun status to the UART core and memory logic.

Parameters:
- `SYNC_STAGES`, 2, flip-flop stages on the rx input synchronizer (minimum 2).
- `K_WIDTH`, 19, width of the bit-time count input.

Ports:
- `clk` input 1: system clock, from the clock input buffer.
- `reset` input 1: synchronous, active-high reset, from the reset input buffer.
- `rx` input 1: serial line from the pad input buffer. Idle high. Asynchronous to `clk`.
- `k` input K_WIDTH: clocks per bit time. Legal range 4..2^K_WIDTH-1. Sampled only in IDLE.
- `eight` input 1: 1 = 8 data bits, 0 = 7 data bits.
- `pen` input 1: parity enable.
- `ohel` input 1: parity sense. 1 = odd, 0 = even.
- `rd` input 1: one-cycle strobe; the consumer has read `rx_data`.
- `rx_data` output 8: last received character, LSB = first data bit.
- `rx_rdy` output 1: character available. Sticky.
- `perr` output 1: parity error on the current character. Sticky.
- `ferr` output 1: framing error, stop bit sampled low. Sticky.
- `ovf` output 1: overrun, new character completed while `rx_rdy` = 1. Sticky.
- `busy` output 1: high in every state except IDLE.

Behaviour:
- Single clock domain; all state changes on the rising edge of `clk`.
- Reset is synchronous and active-high: `reset` = 1 at a rising edge of `clk` forces all state. No asynchronous paths.

Reset values:
- `rx_data` = 0x00; `rx_rdy`, `perr`, `ferr`, `ovf`, `busy` = 0.
- Synchronizer flops = 1.
- FSM = IDLE; bit counter and time counter = 0.

Synchronizer:
- `rx` passes through `SYNC_STAGES` flops; `rxs` = last stage. FSM uses `rxs` only.

Latched configuration and frame length:
- `k`, `eight`, `pen` and `ohel` are latched on IDLE->START. Changes mid-frame have no effect.
- `nbits` = 7 + `eight` + `pen`.

State machine:
- IDLE:
  - `busy` = 0.
  - `rxs` = 0 -> START; time counter cleared.
- START:
  - Count to `k`>>1 (floor).
  - At terminal count, `rxs` = 0 -> DATA, counters cleared.
  - At terminal count, `rxs` = 1 -> false start, back to IDLE. No status change.
- DATA:
  - Count to `k`-1, then sample `rxs` into a right-shifting register and increment the bit counter. Time counter restarts.
  - After `nbits` samples -> STOP.
  - The first sample is taken 1.5 bit times after the falling edge (plus synchronizer delay).
- STOP:
  - Count to `k`-1, then sample the stop bit and go to IDLE in the same edge.
  - On that edge, update the character and status outputs as listed below.

Output update on the STOP sample edge:
- `rx_data` <= assembled data. When `eight` = 0, bit 7 = 0. The parity bit is never placed in `rx_data`.
- `ferr` <= ~stop_bit.
- `perr` <= `pen` & (^data_bits ^ `ohel` ^ parity_bit ^ 1'b0 mismatch). Expected parity = ^data_bits ^ `ohel`; error when it differs from the received parity bit. `perr` = 0 when `pen` = 0.
- `rx_rdy` <= 1.
- `ovf` <= 1 if `rx_rdy` was already 1 and `rd` is not asserted on this edge. Otherwise `ovf` holds.

Read strobe:
- `rd` = 1 clears `rx_rdy`, `perr`, `ferr` and `ovf` on the next edge.
- If `rd` and the STOP update fall on the same edge, the new character's flags win: `rx_rdy` = 1, `ovf` = 0.
- `rd` while `rx_rdy` = 0 is harmless.

Latency: `rx_rdy` rises exactly `SYNC_STAGES` + `k`>>1 + (`nbits`+1)·`k` + 1 clocks after the `rx` falling edge, ±1 clock of synchronizer uncertainty.

Break condition: continuous low gives `ferr` = 1 and `rx_data` = 0x00. The FSM then re-arms from IDLE immediately on `rxs` = 0.

Optional Feature:
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - Every data, parity and stop sample is a 2-of-3 majority of `rxs` taken at terminal count -1, terminal count and terminal count +1.
  - The start check uses the same vote.
  - The decision edge moves 1 clock later; the time counter for the next bit compensates, so bit spacing stays `k`.
  - `k` must be ≥ 6.
- Undefined: single sample at terminal count, exactly as described in Behaviour.

Test Plan:
- Reset, `k`=16, 8N1, send 0xA5 -> `rx_data`=0xA5, `rx_rdy`=1, `perr`=`ferr`=`ovf`=0, `busy` low after the stop sample.
- 7-bit, even parity (`eight`=0, `pen`=1, `ohel`=0), send 0x41 with parity bit 1 -> `perr`=1, `rx_data`=0x41. Repeat with parity bit 0 -> `perr`=0.
- 8N1, send 0x3C with stop bit driven low -> `ferr`=1, `rx_data`=0x3C. Pulse `rd` -> all flags 0 on the next clock.
- Send 0x11 then 0x22 without `rd` -> `rx_data`=0x22, `ovf`=1. Repeat with `rd` on the exact update edge -> `rx_rdy`=1, `ovf`=0.
- 3-clock low glitch on idle `rx` with `k`=16 -> FSM returns to IDLE, no flag or `rx_data` change. Assert `reset` mid-DATA -> all outputs at reset values next clock; the following frame 0x5A is received correctly.
- With `UART_RX_MAJORITY_EN`, inject a 1-clock inverted pulse at mid-bit on every bit of 0x96 -> `rx_data`=0x96, no errors.

Source files
------------

// File: rtl/uart_rx_engine.sv
// UART receive engine: input synchronizer, start-bit qualification, mid-bit sampling, character/status latch.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point.
module uart_rx_engine #(
    parameter int SYNC_STAGES = 2,
    parameter int K_WIDTH     = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic [K_WIDTH-1:0] k,
    input  logic               eight,
    input  logic               pen,
    input  logic               ohel,
    input  logic               rd,
    output logic [7:0]         rx_data,
    output logic               rx_rdy,
    output logic               perr,
    output logic               ferr,
    output logic               ovf,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state, w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                 w_rxs, w_bit, w_tick, w_done;
    logic [K_WIDTH-1:0]   r_k, r_tcnt, w_tc;
    logic                 r_eight, r_pen, r_ohel;
    logic [3:0]           r_bcnt, w_nbits;
    logic [8:0]           r_shift, w_frame;
    logic [7:0]           w_data;
    logic                 w_par, w_perr;

    always_ff @(posedge clk) begin
        if (reset) r_sync <= '1;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
    assign w_rxs = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // Decision taken one clock after terminal count; history holds tc-1 and tc.
    localparam logic [K_WIDTH-1:0] DLY = K_WIDTH'(1);
    logic [1:0] r_hist;
    always_ff @(posedge clk) begin
        if (reset) r_hist <= '1;
        else       r_hist <= {r_hist[0], w_rxs};
    end
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxs) | (r_hist[0] & w_rxs);
`else
    localparam logic [K_WIDTH-1:0] DLY = '0;
    assign w_bit = w_rxs;
`endif

    assign w_nbits = 4'd7 + {3'd0, r_eight} + {3'd0, r_pen};
    assign w_tc    = (r_state == S_START) ? (r_k >> 1) + DLY : r_k - K_WIDTH'(1) + DLY;
    assign w_tick  = (r_tcnt == w_tc);
    assign w_done  = (r_state == S_STOP) && w_tick;
    assign busy    = (r_state != S_IDLE);

    // Align the received bits to bit 0 whatever the frame length.
    assign w_frame = r_shift >> (4'd9 - w_nbits);
    assign w_data  = r_eight ? w_frame[7:0] : {1'b0, w_frame[6:0]};
    assign w_par   = r_eight ? w_frame[8] : w_frame[7];
    assign w_perr  = r_pen & ((^w_data ^ r_ohel) != w_par);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rxs) w_next = S_START;
            S_START: if (w_tick) w_next = w_bit ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && (r_bcnt == w_nbits - 4'd1)) w_next = S_STOP;
            S_STOP:  if (w_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
            r_k     <= '0;
            r_eight <= 1'b0;
            r_pen   <= 1'b0;
            r_ohel  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tcnt <= '0;
                    r_bcnt <= '0;
                    if (!w_rxs) begin
                        r_k     <= k;
                        r_eight <= eight;
                        r_pen   <= pen;
                        r_ohel  <= ohel;
                    end
                end
                S_START: begin
                    r_bcnt <= '0;
                    r_tcnt <= w_tick ? DLY : r_tcnt + K_WIDTH'(1);
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_tcnt  <= DLY;
                        r_shift <= {w_bit, r_shift[8:1]};
                        r_bcnt  <= r_bcnt + 4'd1;
                    end else begin
                        r_tcnt <= r_tcnt + K_WIDTH'(1);
                    end
                end
                default: r_tcnt <= w_tick ? '0 : r_tcnt + K_WIDTH'(1);
            endcase
        end
    end

    // A character completing on the read edge wins over the read clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data <= '0;
            rx_rdy  <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (rd) begin
                rx_rdy <= 1'b0;
                perr   <= 1'b0;
                ferr   <= 1'b0;
                ovf    <= 1'b0;
            end
            if (w_done) begin
                rx_data <= w_data;
                ferr    <= ~w_bit;
                perr    <= w_perr;
                rx_rdy  <= 1'b1;
                if (rx_rdy && !rd) ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: frames are queued with expected results,
// a monitor compares outputs every time the receiver returns to idle.
module tb_uart_rx_engine;

    localparam int K = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Negedge index (from the start-bit negedge) just after the stop decision edge, 8-bit frames.
    localparam int DEC = K/2 + 4 + K*9 + MAJ;

    logic        clk = 0, reset, rx, eight, pen, ohel, rd;
    logic [18:0] k;
    logic [7:0]  rx_data;
    logic        rx_rdy, perr, ferr, ovf, busy;

    typedef struct {
        logic [7:0] d;
        logic       rdy, pe, fe, ov;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_err = 0;
    logic mon_pb = 1'b0;

    uart_rx_engine #(.SYNC_STAGES(2), .K_WIDTH(19)) dut (
        .clk(clk), .reset(reset), .rx(rx), .k(k), .eight(eight), .pen(pen),
        .ohel(ohel), .rd(rd), .rx_data(rx_data), .rx_rdy(rx_rdy), .perr(perr),
        .ferr(ferr), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic rdy, pe, fe, ov, input string nm);
        exp_t e;
        e.d = d; e.rdy = rdy; e.pe = pe; e.fe = fe; e.ov = ov; e.nm = nm;
        return e;
    endfunction

    // Monitor: every busy fall is one receiver event with one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_pb && !busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_idle_qsize", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk({e.nm, "_data"}, rx_data, e.d);
                    chk({e.nm, "_rdy"},  rx_rdy,  e.rdy);
                    chk({e.nm, "_perr"}, perr,    e.pe);
                    chk({e.nm, "_ferr"}, ferr,    e.fe);
                    chk({e.nm, "_ovf"},  ovf,     e.ov);
                end
            end
            mon_pb = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // One 8-bit-wide frame (data or 7 data + parity), stop bit, then two idle bit times.
    task automatic send(input logic [8:0] bits, input logic stop, input int rd_c,
                        input bit lat, input bit glitch);
        int bi;
        logic v;
        for (int c = 0; c < K*12; c++) begin
            @(negedge clk);
            if (lat && c == DEC-1) chk("lat_before", rx_rdy, 0);
            if (lat && c == DEC)   chk("lat_at",     rx_rdy, 1);
            bi = c / K;
            if (bi == 0)      v = 1'b0;
            else if (bi <= 8) v = bits[bi-1];
            else if (bi == 9) v = stop;
            else              v = 1'b1;
            if (glitch && bi >= 1 && bi <= 8 && (c % K) == 9) v = ~v;
            rx = v;
            rd = (c == rd_c);
        end
        rd = 1'b0;
    endtask

    task automatic pulse_rd(input string nm);
        @(negedge clk); rd = 1'b1;
        @(negedge clk); rd = 1'b0;
        chk({nm, "_rd_rdy"},  rx_rdy, 0);
        chk({nm, "_rd_perr"}, perr,   0);
        chk({nm, "_rd_ferr"}, ferr,   0);
        chk({nm, "_rd_ovf"},  ovf,    0);
    endtask

    initial begin
        reset = 1'b1; rx = 1'b1; rd = 1'b0; k = 19'd16;
        eight = 1'b1; pen = 1'b0; ohel = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data", rx_data, 0);
        chk("rst_rdy",  rx_rdy,  0);
        chk("rst_perr", perr,    0);
        chk("rst_ferr", ferr,    0);
        chk("rst_ovf",  ovf,     0);
        chk("rst_busy", busy,    0);
        repeat (5) @(negedge clk);

        // 8N1 0xA5 with exact latency
        q.push_back(mk(8'hA5, 1, 0, 0, 0, "a5"));
        send({1'b0, 8'hA5}, 1'b1, -1, 1, 0);
        pulse_rd("a5");

        // 7E1 0x41: ones even, expected parity 0
        eight = 1'b0; pen = 1'b1; ohel = 1'b0;
        q.push_back(mk(8'h41, 1, 1, 0, 0, "par1"));
        send({2'b01, 7'h41}, 1'b1, -1, 0, 0);
        pulse_rd("par1");
        q.push_back(mk(8'h41, 1, 0, 0, 0, "par0"));
        send({2'b00, 7'h41}, 1'b1, -1, 0, 0);
        pulse_rd("par0");

        // Low stop bit: framing error, then the still-low line re-arms and false-starts
        eight = 1'b1; pen = 1'b0;
        q.push_back(mk(8'h3C, 1, 0, 1, 0, "fe"));
        q.push_back(mk(8'h3C, 1, 0, 1, 0, "fe_fs"));
        send({1'b0, 8'h3C}, 1'b0, -1, 0, 0);
        pulse_rd("fe");

        // Overrun, then read on the exact update edge
        q.push_back(mk(8'h11, 1, 0, 0, 0, "ov1"));
        send({1'b0, 8'h11}, 1'b1, -1, 0, 0);
        q.push_back(mk(8'h22, 1, 0, 0, 1, "ov2"));
        send({1'b0, 8'h22}, 1'b1, -1, 0, 0);
        pulse_rd("ov2");
        q.push_back(mk(8'h11, 1, 0, 0, 0, "ov3"));
        send({1'b0, 8'h11}, 1'b1, -1, 0, 0);
        q.push_back(mk(8'h22, 1, 0, 0, 0, "ov4"));
        send({1'b0, 8'h22}, 1'b1, DEC-1, 0, 0);

        // 3-clock glitch: false start, nothing changes
        q.push_back(mk(8'h22, 1, 0, 0, 0, "glitch"));
        for (int c = 0; c < 3*K; c++) begin
            @(negedge clk);
            rx = (c < 3) ? 1'b0 : 1'b1;
        end

        // Reset in the middle of the data bits
        q.push_back(mk(8'h00, 0, 0, 0, 0, "rst_mid"));
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            rx = (c < K) ? 1'b0 : logic'((c / K) % 2);
        end
        chk("mid_busy", busy, 1);
        @(negedge clk); reset = 1'b1; rx = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_rdy",  rx_rdy,  0);
        chk("mid_rst_busy", busy,    0);
        repeat (K) @(negedge clk);
        q.push_back(mk(8'h5A, 1, 0, 0, 0, "5a"));
        send({1'b0, 8'h5A}, 1'b1, -1, 1, 0);

`ifdef UART_RX_MAJORITY_EN
        pulse_rd("5a");
        q.push_back(mk(8'h96, 1, 0, 0, 0, "maj"));
        send({1'b0, 8'h96}, 1'b1, -1, 0, 1);
`endif

        repeat (20) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
